// File: rtl/vx_nc_mem_responder.sv
// Memory-side target for non-cacheable line traffic: byte-masked writes into a small line array,
// in-order read responses with the request tag echoed after a fixed latency.
module vx_nc_mem_responder #(
  parameter int NUM_PORTS      = 1,
  parameter int CORE_DATA_SIZE = 4,
  parameter int MEM_DATA_SIZE  = 16,
  parameter int MEM_ADDR_WIDTH = 26,
  parameter int MEM_TAG_WIDTH  = 8,
  parameter int NUM_LINES      = 16,
  parameter int LATENCY        = 2,
  parameter int RSP_DEPTH      = 4,
  localparam int CORE_DATA_WIDTH = 8 * CORE_DATA_SIZE,
  localparam int MEM_DATA_WIDTH  = 8 * MEM_DATA_SIZE,
  localparam int NUM_SLOTS       = MEM_DATA_SIZE / CORE_DATA_SIZE,
  localparam int SEL_RAW         = $clog2(NUM_SLOTS),
  localparam int MEM_SELECT_BITS = (SEL_RAW == 0) ? 1 : SEL_RAW,
  localparam int LINE_BITS       = $clog2(NUM_LINES),
  localparam int OUT_W           = $clog2(RSP_DEPTH + 1)
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 mem_req_valid,
  input  logic                                 mem_req_rw,
  input  logic [MEM_ADDR_WIDTH-1:0]            mem_req_addr,
  input  logic [NUM_PORTS-1:0]                 mem_req_pmask,
  input  logic [NUM_PORTS*CORE_DATA_SIZE-1:0]  mem_req_byteen,
  input  logic [NUM_PORTS*MEM_SELECT_BITS-1:0] mem_req_wsel,
  input  logic [NUM_PORTS*CORE_DATA_WIDTH-1:0] mem_req_data,
  input  logic [MEM_TAG_WIDTH-1:0]             mem_req_tag,
  output logic                                 mem_req_ready,
  output logic                                 mem_rsp_valid,
  output logic [MEM_DATA_WIDTH-1:0]            mem_rsp_data,
  output logic [MEM_TAG_WIDTH-1:0]             mem_rsp_tag,
  input  logic                                 mem_rsp_ready,
  output logic [OUT_W-1:0]                     outstanding
);

  localparam int PTR_W = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;

  logic req_fire, rd_fire, wr_fire, rsp_fire;
  logic [LINE_BITS-1:0] req_idx;
  logic unused_addr_hi;

  logic [MEM_DATA_WIDTH-1:0] lines [NUM_LINES];
  logic [MEM_DATA_WIDTH-1:0] wr_line;

  logic                      push_v;
  logic [MEM_DATA_WIDTH-1:0] push_d;
  logic [MEM_TAG_WIDTH-1:0]  push_t;

  logic [MEM_DATA_WIDTH-1:0] fifo_d [RSP_DEPTH];
  logic [MEM_TAG_WIDTH-1:0]  fifo_t [RSP_DEPTH];
  logic [PTR_W-1:0]          rd_ptr, wr_ptr;
  logic [OUT_W-1:0]          fifo_cnt;

  // Reads are throttled on outstanding count, which bounds FIFO occupancy; writes never stall.
  assign mem_req_ready  = mem_req_rw || (outstanding != OUT_W'(RSP_DEPTH));
  assign req_fire       = mem_req_valid && mem_req_ready;
  assign rd_fire        = req_fire && !mem_req_rw;
  assign wr_fire        = req_fire && mem_req_rw;
  assign rsp_fire       = mem_rsp_valid && mem_rsp_ready;
  assign req_idx        = mem_req_addr[LINE_BITS-1:0];
  assign unused_addr_hi = ^mem_req_addr[MEM_ADDR_WIDTH-1:LINE_BITS];

  // Ports merged in ascending order so the highest enabled port wins on overlapping bytes.
  always_comb begin
    wr_line = lines[req_idx];
    for (int unsigned p = 0; p < NUM_PORTS; p++) begin
      for (int unsigned b = 0; b < CORE_DATA_SIZE; b++) begin
        if (mem_req_pmask[p] && mem_req_byteen[p*CORE_DATA_SIZE + b] &&
            (32'(mem_req_wsel[p*MEM_SELECT_BITS +: MEM_SELECT_BITS]) < NUM_SLOTS)) begin
          wr_line[(32'(mem_req_wsel[p*MEM_SELECT_BITS +: MEM_SELECT_BITS]) * CORE_DATA_SIZE + b) * 8 +: 8]
            = mem_req_data[p*CORE_DATA_WIDTH + b*8 +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < NUM_LINES; i++) lines[i] <= '0;
    end else if (wr_fire) begin
      lines[req_idx] <= wr_line;
    end
  end

  // The line is captured at the read fire edge; LATENCY-1 further stages precede the FIFO push.
  if (LATENCY == 1) begin : g_lat1
    assign push_v = rd_fire;
    assign push_d = lines[req_idx];
    assign push_t = mem_req_tag;
  end else begin : g_pipe
    logic                      pv [LATENCY-1];
    logic [MEM_DATA_WIDTH-1:0] pd [LATENCY-1];
    logic [MEM_TAG_WIDTH-1:0]  pt [LATENCY-1];

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        for (int unsigned i = 0; i < LATENCY - 1; i++) begin
          pv[i] <= 1'b0;
          pd[i] <= '0;
          pt[i] <= '0;
        end
      end else begin
        pv[0] <= rd_fire;
        pd[0] <= lines[req_idx];
        pt[0] <= mem_req_tag;
        for (int unsigned i = 1; i < LATENCY - 1; i++) begin
          pv[i] <= pv[i-1];
          pd[i] <= pd[i-1];
          pt[i] <= pt[i-1];
        end
      end
    end

    assign push_v = pv[LATENCY-2];
    assign push_d = pd[LATENCY-2];
    assign push_t = pt[LATENCY-2];
  end

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (32'(p) == RSP_DEPTH - 1) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < RSP_DEPTH; i++) begin
        fifo_d[i] <= '0;
        fifo_t[i] <= '0;
      end
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      fifo_cnt    <= '0;
      outstanding <= '0;
    end else begin
      if (push_v) begin
        fifo_d[wr_ptr] <= push_d;
        fifo_t[wr_ptr] <= push_t;
        wr_ptr         <= ptr_inc(wr_ptr);
      end
      if (rsp_fire) rd_ptr <= ptr_inc(rd_ptr);
      case ({push_v, rsp_fire})
        2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
        2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
        default: fifo_cnt <= fifo_cnt;
      endcase
      case ({rd_fire, rsp_fire})
        2'b10:   outstanding <= outstanding + 1'b1;
        2'b01:   outstanding <= outstanding - 1'b1;
        default: outstanding <= outstanding;
      endcase
    end
  end

  assign mem_rsp_valid = (fifo_cnt != '0);
  assign mem_rsp_data  = fifo_d[rd_ptr];
  assign mem_rsp_tag   = fifo_t[rd_ptr];

  a_no_fifo_overflow: assert property (@(posedge clk) disable iff (reset)
    !(push_v && (fifo_cnt == OUT_W'(RSP_DEPTH))));

endmodule

// File: tb/tb_vx_nc_mem_responder.sv
// Randomized bench for vx_nc_mem_responder (2 word ports) with directed scenarios,
// checked every cycle against a line-array + response-queue reference model.
module tb_vx_nc_mem_responder;

  localparam int LATENCY   = 2;
  localparam int RSP_DEPTH = 4;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         mem_req_valid = 1'b0;
  logic         mem_req_rw = 1'b0;
  logic [25:0]  mem_req_addr = '0;
  logic [1:0]   mem_req_pmask = '0;
  logic [7:0]   mem_req_byteen = '0;
  logic [3:0]   mem_req_wsel = '0;
  logic [63:0]  mem_req_data = '0;
  logic [7:0]   mem_req_tag = '0;
  logic         mem_req_ready;
  logic         mem_rsp_valid;
  logic [127:0] mem_rsp_data;
  logic [7:0]   mem_rsp_tag;
  logic         mem_rsp_ready = 1'b0;
  logic [2:0]   outstanding;

  vx_nc_mem_responder #(
    .NUM_PORTS (2),
    .LATENCY   (LATENCY),
    .RSP_DEPTH (RSP_DEPTH)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .mem_req_valid  (mem_req_valid),
    .mem_req_rw     (mem_req_rw),
    .mem_req_addr   (mem_req_addr),
    .mem_req_pmask  (mem_req_pmask),
    .mem_req_byteen (mem_req_byteen),
    .mem_req_wsel   (mem_req_wsel),
    .mem_req_data   (mem_req_data),
    .mem_req_tag    (mem_req_tag),
    .mem_req_ready  (mem_req_ready),
    .mem_rsp_valid  (mem_rsp_valid),
    .mem_rsp_data   (mem_rsp_data),
    .mem_rsp_tag    (mem_rsp_tag),
    .mem_rsp_ready  (mem_rsp_ready),
    .outstanding    (outstanding)
  );

  always #5 clk = ~clk;

  // Reference model: line contents plus accepted reads awaiting return, each with its earliest cycle.
  typedef struct {
    logic [7:0]   tag;
    logic [127:0] data;
    int           due;
  } rsp_t;

  logic [127:0] mline [16];
  rsp_t         q [$];
  int           cyc = 0;
  int           n_vec = 0;
  int           n_err = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic exp_valid();
    if (q.size() == 0) return 1'b0;
    return (q[0].due <= cyc);
  endfunction

  task automatic check_outputs();
    logic ev;
    ev = exp_valid();
    check("rsp_valid", 128'(mem_rsp_valid), 128'(ev));
    check("outstanding", 128'(outstanding), 128'(q.size()));
    if (ev && mem_rsp_valid) begin
      check("rsp_tag", 128'(mem_rsp_tag), 128'(q[0].tag));
      check("rsp_data", mem_rsp_data, q[0].data);
    end
  endtask

  task automatic cycle(input logic v, input logic rw, input logic [25:0] a, input logic [1:0] pm,
                       input logic [7:0] be, input logic [3:0] ws, input logic [63:0] d,
                       input logic [7:0] t, input logic rr);
    logic         er, req_f, rsp_f;
    logic [127:0] line;
    logic [1:0]   slot;
    mem_req_valid  = v;
    mem_req_rw     = rw;
    mem_req_addr   = a;
    mem_req_pmask  = pm;
    mem_req_byteen = be;
    mem_req_wsel   = ws;
    mem_req_data   = d;
    mem_req_tag    = t;
    mem_rsp_ready  = rr;
    #1;
    er = rw || (q.size() != RSP_DEPTH);
    check("req_ready", 128'(mem_req_ready), 128'(er));
    req_f = v && er;
    rsp_f = exp_valid() && rr;
    @(posedge clk);
    if (rsp_f) void'(q.pop_front());
    if (req_f && rw) begin
      line = mline[a[3:0]];
      for (int p = 0; p < 2; p++)
        if (pm[p])
          for (int b = 0; b < 4; b++)
            if (be[p*4+b]) begin
              slot = ws[p*2 +: 2];
              line[(int'(slot)*4 + b)*8 +: 8] = d[p*32 + b*8 +: 8];
            end
      mline[a[3:0]] = line;
    end
    if (req_f && !rw) q.push_back('{tag: t, data: mline[a[3:0]], due: cyc + LATENCY});
    cyc++;
    @(negedge clk);
    check_outputs();
  endtask

  task automatic rd(input logic [25:0] a, input logic [7:0] t, input logic rr);
    cycle(1'b1, 1'b0, a, 2'b00, 8'h00, 4'h0, 64'h0, t, rr);
  endtask

  task automatic wr(input logic [25:0] a, input logic [1:0] pm, input logic [7:0] be,
                    input logic [3:0] ws, input logic [63:0] d, input logic rr);
    cycle(1'b1, 1'b1, a, pm, be, ws, d, 8'h00, rr);
  endtask

  task automatic idle(input logic rr);
    cycle(1'b0, 1'b0, 26'h0, 2'b00, 8'h00, 4'h0, 64'h0, 8'h00, rr);
  endtask

  task automatic do_reset();
    mem_req_valid = 1'b0;
    mem_req_rw    = 1'b0;
    mem_rsp_ready = 1'b0;
    reset = 1'b1;
    #1;
    check("rst_valid", 128'(mem_rsp_valid), 128'(0));
    check("rst_ready", 128'(mem_req_ready), 128'(1));
    check("rst_data", mem_rsp_data, 128'h0);
    check("rst_tag", 128'(mem_rsp_tag), 128'(0));
    check("rst_outstanding", 128'(outstanding), 128'(0));
    q.delete();
    for (int i = 0; i < 16; i++) mline[i] = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check_outputs();
  endtask

  initial begin
    #3;
    do_reset();

    // Partial word write then read of the same line.
    wr(26'd3, 2'b01, 8'h03, 4'h1, 64'hAABBCCDD, 1'b0);
    rd(26'd3, 8'h81, 1'b1);
    idle(1'b0);
    check("t1_valid", 128'(mem_rsp_valid), 128'(1));
    check("t1_data", mem_rsp_data, 128'h0000_0000_0000_0000_0000_CCDD_0000_0000);
    check("t1_tag", 128'(mem_rsp_tag), 128'h81);
    idle(1'b1);

    // Fill the response buffer; a further read is refused, a write still goes in.
    for (int i = 0; i < 4; i++) rd(26'(i), 8'(i + 1), 1'b0);
    check("t2_outstanding", 128'(outstanding), 128'(4));
    check("t2_ready_full", 128'(mem_req_ready), 128'(0));
    wr(26'd8, 2'b01, 8'h0F, 4'h0, 64'h12345678, 1'b0);
    check("t3_outstanding", 128'(outstanding), 128'(4));
    for (int i = 0; i < 4; i++) begin
      check("t2_order", 128'(mem_rsp_tag), 128'(i + 1));
      idle(1'b1);
    end

    // Read fire coinciding with response fire keeps the count.
    rd(26'd8, 8'h21, 1'b0);
    rd(26'd9, 8'h22, 1'b0);
    idle(1'b0);
    rd(26'd1, 8'h23, 1'b1);
    check("t4_outstanding", 128'(outstanding), 128'(2));
    repeat (6) idle(1'b1);

    // Two ports writing the same word: the higher port wins.
    wr(26'd5, 2'b11, 8'hFF, 4'h0, {32'h2, 32'h1}, 1'b0);
    rd(26'd5, 8'h06, 1'b1);
    idle(1'b0);
    check("t6_data", mem_rsp_data, 128'h2);
    idle(1'b1);

    // Reset with reads in flight drops them and clears the lines.
    rd(26'd3, 8'h31, 1'b0);
    rd(26'd5, 8'h32, 1'b0);
    rd(26'd8, 8'h33, 1'b0);
    do_reset();
    repeat (6) idle(1'b1);
    rd(26'd3, 8'h44, 1'b1);
    idle(1'b0);
    check("t5_data", mem_rsp_data, 128'h0);
    check("t5_tag", 128'(mem_rsp_tag), 128'h44);
    idle(1'b1);

    // Random traffic, including aliased addresses above the line index.
    for (int n = 0; n < 1500; n++) begin
      cycle(($urandom_range(0, 9) < 7), ($urandom_range(0, 9) < 4), 26'($urandom_range(0, 31)),
            2'($urandom), 8'($urandom), 4'($urandom), {$urandom, $urandom}, 8'($urandom),
            ($urandom_range(0, 9) < 6));
    end
    repeat (10) idle(1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
